// File: rtl/cau_sched.sv
// Round-robin scheduler sharing one complex arithmetic unit (CAU) between NUM_REQ requesters.
// Optional sticky overflow flag is enabled by defining CAU_SCHED_OVF_STICKY_EN.
module cau_sched #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a_r,
    input  logic [DATA_W*NUM_REQ-1:0] req_a_i,
    input  logic [DATA_W*NUM_REQ-1:0] req_b_r,
    input  logic [DATA_W*NUM_REQ-1:0] req_b_i,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_s_r,
    output logic [DATA_W-1:0]         rsp_s_i,
    output logic                      rsp_ovf,
    output logic                      rsp_err,
    output logic                      ovf_sticky,
    input  logic                      ovf_clr
);

    // Handshake rule: a transfer happens on a rising edge where valid && ready are both high.
    // Valid never waits for ready; the holder of valid keeps its payload stable until the transfer.

    // Sign-magnitude format: MSB is the sign, the rest is magnitude with FRAC_W fraction bits.
    localparam int MW     = DATA_W - 1;
    localparam int FRAC_W = DATA_W - 2;
    localparam int PW     = 2 * DATA_W + 1;

    function automatic logic signed [PW-1:0] sm2s(input logic [DATA_W-1:0] x);
        logic signed [PW-1:0] m;
        m = $signed({{(PW-MW){1'b0}}, x[MW-1:0]});
        return x[DATA_W-1] ? -m : m;
    endfunction

    // Back to sign-magnitude; out-of-range magnitudes saturate and raise the overflow bit (MSB).
    function automatic logic [DATA_W:0] sm_pack(input logic signed [PW-1:0] v, input logic shift);
        logic [PW-1:0] mag;
        logic          neg;
        logic          ovf;
        neg = v[PW-1];
        mag = neg ? -v : v;
        if (shift) mag = mag >> FRAC_W;
        ovf = |mag[PW-1:MW];
        if (ovf) return {1'b1, neg, {MW{1'b1}}};
        return {1'b0, neg && (mag != '0), mag[MW-1:0]};
    endfunction

    // ---------------- arbitration ----------------
    logic [ID_W-1:0]    last_q;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic [NUM_REQ-1:0] grant_vec;
    int                 arb_idx;

    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        arb_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_idx = int'(last_q) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (!win_found && req_valid[ID_W'(arb_idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(arb_idx);
            end
        end
    end

    // ---------------- pipeline control ----------------
    logic s1_valid;
    logic s1_load;
    logic s2_load;
    logic hs;

    assign s2_load = !rsp_valid || rsp_ready;
    assign s1_load = !s1_valid || s2_load;
    assign hs      = win_found && s1_load && !rst;

    always_comb begin
        grant_vec         = '0;
        grant_vec[win_id] = 1'b1;
        req_ready         = hs ? grant_vec : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (hs) begin
            last_q <= win_id;
        end
    end

    // ---------------- stage 1: issue register ----------------
    logic [1:0]        win_op;
    logic [DATA_W-1:0] win_a_r, win_a_i, win_b_r, win_b_i;
    logic [ID_W-1:0]   s1_id;
    logic              s1_sum, s1_abs, s1_err;
    logic [DATA_W-1:0] s1_a_r, s1_a_i, s1_b_r, s1_b_i;

    assign win_op  = req_op[win_id*2 +: 2];
    assign win_a_r = req_a_r[win_id*DATA_W +: DATA_W];
    assign win_a_i = req_a_i[win_id*DATA_W +: DATA_W];
    assign win_b_r = req_b_r[win_id*DATA_W +: DATA_W];
    assign win_b_i = req_b_i[win_id*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_sum   <= 1'b0;
            s1_abs   <= 1'b0;
            s1_err   <= 1'b0;
            s1_a_r   <= '0;
            s1_a_i   <= '0;
            s1_b_r   <= '0;
            s1_b_i   <= '0;
        end else if (s1_load) begin
            s1_valid <= hs;
            if (hs) begin
                s1_id  <= win_id;
                s1_sum <= (win_op == 2'b01);
                s1_abs <= (win_op == 2'b10);
                s1_err <= (win_op == 2'b11);
                s1_a_r <= win_a_r;
                s1_a_i <= win_a_i;
                s1_b_r <= win_b_r;
                s1_b_i <= win_b_i;
            end
        end
    end

    // ---------------- CAU: combinational between stage 1 and stage 2 ----------------
    logic signed [PW-1:0] xa_r, xa_i, xb_r, xb_i;
    logic signed [PW-1:0] acc_r, acc_i;
    logic                 cau_shift;
    logic [DATA_W:0]      cau_pr, cau_pi;
    logic                 cau_ovf;

    always_comb begin
        xa_r      = sm2s(s1_a_r);
        xa_i      = sm2s(s1_a_i);
        xb_r      = sm2s(s1_b_r);
        xb_i      = sm2s(s1_b_i);
        acc_r     = '0;
        acc_i     = '0;
        cau_shift = 1'b1;
        if (s1_sum) begin
            acc_r     = xa_r + xb_r;
            acc_i     = xa_i + xb_i;
            cau_shift = 1'b0;
        end else if (s1_abs) begin
            // A * conj(A) is purely real; B is not looked at.
            acc_r = xa_r * xa_r + xa_i * xa_i;
            acc_i = '0;
        end else begin
            acc_r = xa_r * xb_r - xa_i * xb_i;
            acc_i = xa_r * xb_i + xa_i * xb_r;
        end
        cau_pr  = sm_pack(acc_r, cau_shift);
        cau_pi  = sm_pack(acc_i, cau_shift);
        cau_ovf = cau_pr[DATA_W] | cau_pi[DATA_W];
    end

    // ---------------- stage 2: response register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_s_r   <= '0;
            rsp_s_i   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (s2_load) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id  <= s1_id;
                rsp_err <= s1_err;
                rsp_s_r <= s1_err ? '0 : cau_pr[DATA_W-1:0];
                rsp_s_i <= s1_err ? '0 : cau_pi[DATA_W-1:0];
                rsp_ovf <= s1_err ? 1'b0 : cau_ovf;
            end
        end
    end

`ifdef CAU_SCHED_OVF_STICKY_EN
    logic ovf_sticky_q;

    // A new overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
        end else if (s2_load && s1_valid && !s1_err && cau_ovf) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = 1'b0;
`endif

endmodule
